// File: rtl/uart_bus_sequencer.sv
// uart_bus_sequencer: turns UART command frames into bridge master transactions and streams read data back out of UART TX.
// Latency: m_instruction one cycle after the last header byte (read) or the first buffered data byte (write); u_send_sig one cycle after a byte is buffered and TX is free.
// Backpressure: write bytes wait in a FIFO for m_tx_done; read bytes wait for u_tx_busy low; reads arriving at a full FIFO are dropped (err_overflow). Define STATUS_ACK_EN to append a status byte per frame.
module uart_bus_sequencer #(
    parameter int SLAVE_LEN      = 2,
    parameter int ADDR_LEN       = 12,
    parameter int DATA_LEN       = 8,
    parameter int BURST_LEN      = 12,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 u_receive_sig,
    input  logic [DATA_LEN-1:0]  u_data_in,
    input  logic                 u_tx_busy,
    input  logic                 u_tx_done,
    output logic                 u_send_sig,
    output logic [DATA_LEN-1:0]  u_data_out,
    output logic [1:0]           m_instruction,
    output logic [SLAVE_LEN-1:0] m_slave_select,
    output logic [ADDR_LEN-1:0]  m_address,
    output logic [BURST_LEN-1:0] m_burst_num,
    output logic [DATA_LEN-1:0]  m_data_out,
    input  logic [DATA_LEN-1:0]  m_data_in,
    input  logic                 m_new_rx,
    input  logic                 m_rx_done,
    input  logic                 m_tx_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [1:0]    OP_READ  = 2'b01;
    localparam logic [1:0]    OP_WRITE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_BHI, S_BLO, S_ISSUE, S_WRITE, S_READ, S_DRAIN
`ifdef STATUS_ACK_EN
        , S_ACK
`endif
    } state_t;

`ifdef STATUS_ACK_EN
    localparam state_t S_END = S_ACK;
`else
    localparam state_t S_END = S_IDLE;
`endif

    state_t state, state_n;

    logic [1:0]           op_q;
    logic                 hdr_ok;
    logic [BURST_LEN-1:0] burst_next;
    logic [BURST_LEN-1:0] rcv_cnt, tx_cnt;
    logic                 owed, last_beat;

    logic [DATA_LEN-1:0]  wf_mem [FIFO_DEPTH];
    logic [PW-1:0]        wf_wr, wf_rd;
    logic [CW-1:0]        wf_cnt;
    logic                 wf_empty, wf_full, wf_push, wf_pop;

    logic [DATA_LEN-1:0]  rf_mem [FIFO_DEPTH];
    logic [PW-1:0]        rf_wr, rf_rd;
    logic [CW-1:0]        rf_cnt;
    logic                 rf_empty, rf_full, rf_push_req, rf_push, rf_pop, rf_ovf;
    logic [DATA_LEN-1:0]  rf_push_dat;
    logic                 in_flight;

    logic [TW-1:0]        to_cnt;
    logic                 to_run, to_hold, to_hit;

    assign hdr_ok     = (u_data_in[7:6] == OP_READ) || (u_data_in[7:6] == OP_WRITE);
    assign burst_next = {m_burst_num[11:8], u_data_in};
    assign owed       = rcv_cnt < m_burst_num;
    assign busy       = (state != S_IDLE);

    assign wf_empty   = (wf_cnt == '0);
    assign wf_full    = (wf_cnt == DEPTH_C);
    assign wf_push    = ((state == S_ISSUE) || (state == S_WRITE)) && u_receive_sig && owed && !wf_full;
    assign wf_pop     = (state == S_WRITE) && m_tx_done && !wf_empty;
    assign last_beat  = wf_pop && ((tx_cnt + BURST_LEN'(1)) == m_burst_num);
    assign m_data_out = wf_empty ? '0 : wf_mem[wf_rd];

    // Timeout only runs while a frame byte is owed; bridge back-pressure in WRITE holds it
    assign to_run  = (state == S_ADDR) || (state == S_BHI) || (state == S_BLO) ||
                     ((state == S_WRITE) && wf_empty && owed);
    assign to_hold = (state == S_WRITE) && !wf_empty;
    assign to_hit  = to_run && !u_receive_sig && (to_cnt == TO_LAST);

    assign rf_empty = (rf_cnt == '0);
    assign rf_full  = (rf_cnt == DEPTH_C);
    assign rf_pop   = !rf_empty && !u_tx_busy && !in_flight;

`ifdef STATUS_ACK_EN
    logic                txn_err;
    logic [DATA_LEN-1:0] status;

    // Remember whether the current frame hit an error so ACK can report it
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE)) txn_err <= 1'b0;
        else if (to_hit || rf_ovf)      txn_err <= 1'b1;
    end

    assign status      = txn_err ? (DATA_LEN'(8'hE0) | DATA_LEN'({err_overflow, err_timeout}))
                                 : DATA_LEN'(8'hA5);
    assign rf_push_req = ((state == S_READ) && m_new_rx) || (state == S_ACK);
    assign rf_push_dat = (state == S_ACK) ? status : m_data_in;
`else
    assign rf_push_req = (state == S_READ) && m_new_rx;
    assign rf_push_dat = m_data_in;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves
    assign rf_push = rf_push_req && (!rf_full || rf_pop);
    assign rf_ovf  = rf_push_req && rf_full && !rf_pop;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state and single-cycle bus instruction
    always_comb begin
        state_n       = state;
        m_instruction = 2'b00;
        case (state)
            S_IDLE:  if (u_receive_sig && hdr_ok) state_n = S_ADDR;
            S_ADDR:  if (to_hit) state_n = S_END; else if (u_receive_sig) state_n = S_BHI;
            S_BHI:   if (to_hit) state_n = S_END; else if (u_receive_sig) state_n = S_BLO;
            S_BLO: begin
                if (to_hit)             state_n = S_END;
                else if (u_receive_sig) state_n = (burst_next == '0) ? S_END : S_ISSUE;
            end
            S_ISSUE: begin
                if (op_q == OP_READ) begin
                    m_instruction = OP_READ;
                    state_n       = S_READ;
                end else if (!wf_empty) begin
                    m_instruction = OP_WRITE;
                    state_n       = S_WRITE;
                end
            end
            S_WRITE: if (to_hit) state_n = S_END; else if (last_beat) state_n = S_DRAIN;
            S_READ:  if (m_rx_done) state_n = S_DRAIN;
            S_DRAIN: if (rf_empty && !in_flight) state_n = S_END;
`ifdef STATUS_ACK_EN
            S_ACK:   state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // Capture header fields as each frame byte arrives; they stay put until the next frame
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q           <= 2'b00;
            m_slave_select <= '0;
            m_address      <= '0;
            m_burst_num    <= '0;
        end else if (u_receive_sig) begin
            case (state)
                S_IDLE: if (hdr_ok) begin
                    op_q              <= u_data_in[7:6];
                    m_slave_select    <= u_data_in[5:4];
                    m_address[11:8]   <= u_data_in[3:0];
                end
                S_ADDR:  m_address[7:0]    <= u_data_in;
                S_BHI:   m_burst_num[11:8] <= u_data_in[3:0];
                S_BLO:   m_burst_num[7:0]  <= u_data_in;
                default: ;
            endcase
        end
    end

    // Count write bytes taken from UART and bytes accepted by the bridge
    always_ff @(posedge clk) begin
        if (reset || !((state == S_ISSUE) || (state == S_WRITE))) begin
            rcv_cnt <= '0;
            tx_cnt  <= '0;
        end else begin
            if (wf_push) rcv_cnt <= rcv_cnt + BURST_LEN'(1);
            if (wf_pop)  tx_cnt  <= tx_cnt + BURST_LEN'(1);
        end
    end

    // Inter-byte timeout counter
    always_ff @(posedge clk) begin
        if (reset || u_receive_sig || to_hit) to_cnt <= '0;
        else if (to_run)                      to_cnt <= to_cnt + TW'(1);
        else if (!to_hold)                    to_cnt <= '0;
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (to_hit) err_timeout  <= 1'b1;
            if (rf_ovf) err_overflow <= 1'b1;
        end
    end

    // Write FIFO storage
    always_ff @(posedge clk) begin
        if (wf_push) wf_mem[wf_wr] <= u_data_in;
    end

    // Write FIFO pointers; a timeout abort flushes whatever was buffered
    always_ff @(posedge clk) begin
        if (reset || to_hit) begin
            wf_wr  <= '0;
            wf_rd  <= '0;
            wf_cnt <= '0;
        end else begin
            if (wf_push) wf_wr <= wf_wr + PW'(1);
            if (wf_pop)  wf_rd <= wf_rd + PW'(1);
            wf_cnt <= wf_cnt + CW'(wf_push) - CW'(wf_pop);
        end
    end

    // Read FIFO storage
    always_ff @(posedge clk) begin
        if (rf_push) rf_mem[rf_wr] <= rf_push_dat;
    end

    // Read FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr  <= '0;
            rf_rd  <= '0;
            rf_cnt <= '0;
        end else begin
            if (rf_push) rf_wr <= rf_wr + PW'(1);
            if (rf_pop)  rf_rd <= rf_rd + PW'(1);
            rf_cnt <= rf_cnt + CW'(rf_push) - CW'(rf_pop);
        end
    end

    // UART TX launch: one byte at a time, held in flight until the transmitter reports done
    always_ff @(posedge clk) begin
        if (reset) begin
            u_send_sig <= 1'b0;
            u_data_out <= '0;
            in_flight  <= 1'b0;
        end else begin
            u_send_sig <= rf_pop;
            if (rf_pop) begin
                u_data_out <= rf_mem[rf_rd];
                in_flight  <= 1'b1;
            end else if (u_tx_done) begin
                in_flight  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Bench for uart_bus_sequencer: directed frames, a frame-level expectation model, one per-cycle compare process.
module tb_uart_bus_sequencer;

    localparam int TO    = 64;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        u_receive_sig;
    logic [7:0]  u_data_in;
    logic        u_tx_busy;
    logic        u_tx_done;
    logic        u_send_sig;
    logic [7:0]  u_data_out;
    logic [1:0]  m_instruction;
    logic [1:0]  m_slave_select;
    logic [11:0] m_address;
    logic [11:0] m_burst_num;
    logic [7:0]  m_data_out;
    logic [7:0]  m_data_in;
    logic        m_new_rx;
    logic        m_rx_done;
    logic        m_tx_done;
    logic        busy;
    logic        err_timeout;
    logic        err_overflow;

    uart_bus_sequencer #(
        .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12),
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .u_receive_sig(u_receive_sig), .u_data_in(u_data_in),
        .u_tx_busy(u_tx_busy), .u_tx_done(u_tx_done),
        .u_send_sig(u_send_sig), .u_data_out(u_data_out),
        .m_instruction(m_instruction), .m_slave_select(m_slave_select),
        .m_address(m_address), .m_burst_num(m_burst_num),
        .m_data_out(m_data_out), .m_data_in(m_data_in),
        .m_new_rx(m_new_rx), .m_rx_done(m_rx_done), .m_tx_done(m_tx_done),
        .busy(busy), .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  slave;
        logic [11:0] addr;
        logic [11:0] burst;
    } txn_t;

    txn_t       exp_txn[$];
    logic [7:0] exp_wd[$];
    logic [7:0] exp_tx[$];
    txn_t       cur, last;
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         owed     = 0;
    int         held     = 0;
    int         sent_cnt = 0;
    int         tx_left  = 0;
    logic       tx_hold  = 1'b0;
    logic       active   = 1'b0;
    logic [1:0] prev_instr = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: decode header, queue the bus transaction the frame must produce
    task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        txn_t t;
        t.op    = b0[7:6];
        t.slave = b0[5:4];
        t.addr  = {b0[3:0], b1};
        t.burst = {b2[3:0], b3};
        if ((t.op == 2'b01 || t.op == 2'b10) && t.burst != 12'd0) begin
            exp_txn.push_back(t);
            if (t.op == 2'b10) owed = int'(t.burst);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk); #1;
        u_receive_sig = 1'b1;
        u_data_in     = b;
        @(posedge clk); #1;
        u_receive_sig = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        model_frame(b0, b1, b2, b3);
        rx_byte(b0); rx_byte(b1); rx_byte(b2); rx_byte(b3);
    endtask

    task automatic send_data(input logic [7:0] b);
        if (owed > 0) begin
            exp_wd.push_back(b);
            owed--;
        end
        rx_byte(b);
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1; m_tx_done = 1'b1;
        @(posedge clk); #1; m_tx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic bridge_rx(input logic [7:0] b);
        if (!tx_hold || held < DEPTH) exp_tx.push_back(b);
        if (tx_hold) held++;
        @(posedge clk); #1; m_new_rx = 1'b1; m_data_in = b;
        @(posedge clk); #1; m_new_rx = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_rx_done();
        @(posedge clk); #1; m_rx_done = 1'b1;
        @(posedge clk); #1; m_rx_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (busy !== 1'b0 && i < 300);
        check(name, {63'b0, busy}, 64'd0);
    endtask

    // UART transmitter model: busy for a few cycles after each send, then a done pulse
    initial begin
        u_tx_busy = 1'b0;
        u_tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            u_tx_done = 1'b0;
            if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) u_tx_done = 1'b1;
            end else if (u_send_sig) begin
                tx_left = 3;
            end
            u_tx_busy = tx_hold || (tx_left > 0);
        end
    end

    // Per-cycle comparison of DUT outputs against the model queues
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                active     = 1'b0;
                prev_instr = 2'b00;
            end else begin
                if (m_instruction != 2'b00) begin
                    check("instr_one_cycle", {62'b0, prev_instr}, 64'd0);
                    if (exp_txn.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL instr_unexpected: got %b, expected 00", m_instruction);
                    end else begin
                        cur = exp_txn.pop_front();
                        check("instr_op",    {62'b0, m_instruction},  {62'b0, cur.op});
                        check("instr_slave", {62'b0, m_slave_select}, {62'b0, cur.slave});
                        check("instr_addr",  {52'b0, m_address},      {52'b0, cur.addr});
                        check("instr_burst", {52'b0, m_burst_num},    {52'b0, cur.burst});
                        active = 1'b1;
                    end
                    last.op    = m_instruction;
                    last.slave = m_slave_select;
                    last.addr  = m_address;
                    last.burst = m_burst_num;
                end else if (active) begin
                    if (busy) begin
                        check("hold_addr",  {52'b0, m_address},      {52'b0, cur.addr});
                        check("hold_slave", {62'b0, m_slave_select}, {62'b0, cur.slave});
                        check("hold_burst", {52'b0, m_burst_num},    {52'b0, cur.burst});
                    end else begin
                        active = 1'b0;
                    end
                end
                if (m_tx_done) begin
                    if (exp_wd.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL wdata_unexpected: got 0x%0h, expected no write beat", m_data_out);
                    end else begin
                        check("wdata", {56'b0, m_data_out}, {56'b0, exp_wd.pop_front()});
                    end
                end
                if (u_send_sig) begin
                    sent_cnt++;
                    if (exp_tx.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL uart_unexpected: got 0x%0h, expected no send", u_data_out);
                    end else begin
                        check("uart_byte", {56'b0, u_data_out}, {56'b0, exp_tx.pop_front()});
                    end
                end
                prev_instr = m_instruction;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; u_receive_sig = 1'b0; u_data_in = 8'h00;
        m_data_in = 8'h00; m_new_rx = 1'b0; m_rx_done = 1'b0; m_tx_done = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", {16'b0, u_send_sig, u_data_out, m_instruction, m_slave_select, m_address,
                                m_burst_num, m_data_out, busy, err_timeout, err_overflow}, 64'd0);
        reset = 1'b0;

        // 1: write burst of 2
        send_frame(8'h94, 8'h10, 8'h00, 8'h02);
        send_data(8'hAA);
        send_data(8'h55);
        @(negedge clk);
        check("t1_busy_pending", {63'b0, busy}, 64'd1);
        pulse_tx_done();
        pulse_tx_done();
        wait_idle("t1_idle");
        check("t1_op",    {62'b0, last.op},    64'h2);
        check("t1_slave", {62'b0, last.slave}, 64'h1);
        check("t1_addr",  {52'b0, last.addr},  64'h410);
        check("t1_burst", {52'b0, last.burst}, 64'h2);

        // 2: read burst of 3 returned over UART
        sent_cnt = 0;
        send_frame(8'h63, 8'h20, 8'h00, 8'h03);
        repeat (2) @(posedge clk);
        bridge_rx(8'h11);
        bridge_rx(8'h22);
        bridge_rx(8'h33);
        pulse_rx_done();
        wait_idle("t2_idle");
        check("t2_op",       {62'b0, last.op},    64'h1);
        check("t2_addr",     {52'b0, last.addr},  64'h320);
        check("t2_sent",     64'(sent_cnt),       64'd3);
        check("t2_no_ovf",   {63'b0, err_overflow}, 64'd0);

        // 3: read overflow while UART is held busy
        sent_cnt = 0;
        held     = 0;
        tx_hold  = 1'b1;
        send_frame(8'h41, 8'h00, 8'h00, 8'h06);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) bridge_rx(8'hB0 + 8'(i));
        @(negedge clk);
        check("t3_ovf",       {63'b0, err_overflow}, 64'd1);
        check("t3_none_sent", 64'(sent_cnt),         64'd0);
        pulse_rx_done();
        repeat (4) @(negedge clk);
        check("t3_drain_busy", {63'b0, busy}, 64'd1);
        tx_hold = 1'b0;
        wait_idle("t3_idle");
        check("t3_sent", 64'(sent_cnt), 64'd4);

        // 4: timeout after two header bytes
        rx_byte(8'h94);
        rx_byte(8'h10);
        repeat (TO - 8) @(posedge clk);
        @(negedge clk);
        check("t4_no_to_yet", {63'b0, err_timeout}, 64'd0);
        check("t4_busy",      {63'b0, busy},        64'd1);
        repeat (10) @(negedge clk);
        check("t4_timeout",   {63'b0, err_timeout}, 64'd1);
        check("t4_idle",      {63'b0, busy},        64'd0);
        check("t4_ovf_stick", {63'b0, err_overflow}, 64'd1);

        // 5: reset in the middle of a write, then a clean write
        send_frame(8'h94, 8'h10, 8'h00, 8'h02);
        send_data(8'hAA);
        send_data(8'h55);
        pulse_tx_done();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_reset_outputs", {16'b0, u_send_sig, u_data_out, m_instruction, m_slave_select, m_address,
                                   m_burst_num, m_data_out, busy, err_timeout, err_overflow}, 64'd0);
        reset = 1'b0;
        exp_wd.delete();
        owed = 0;
        send_frame(8'hA2, 8'h34, 8'h00, 8'h01);
        send_data(8'h7E);
        send_data(8'h99);
        pulse_tx_done();
        wait_idle("t5_idle");
        check("t5_slave", {62'b0, last.slave}, 64'h2);
        check("t5_addr",  {52'b0, last.addr},  64'h234);

        // 6: illegal op and zero-length burst cause no bus activity
        rx_byte(8'hC0);
        @(negedge clk);
        check("t6_illegal_idle", {63'b0, busy}, 64'd0);
        send_frame(8'h94, 8'h10, 8'h00, 8'h00);
        wait_idle("t6_zero_idle");
        check("t6_last_addr", {52'b0, last.addr}, 64'h234);

        repeat (5) @(negedge clk);
        check("end_txn_q",  64'(exp_txn.size()), 64'd0);
        check("end_wd_q",   64'(exp_wd.size()),  64'd0);
        check("end_tx_q",   64'(exp_tx.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_sequencer.md
Name: uart_bus_sequencer

Overview:
Command sequencer between the UART byte interface and the master port of the UART-to-bus bridge. It parses the UART receive byte stream into bus command frames and drives instruction, slave select, address, burst length and write data onto the bridge master port. Read data returned by the bridge is buffered and streamed back out through UART transmit. It sits beside the bridge and owns all sequencing of bridge master transactions.

Parameters:
SLAVE_LEN, 2, slave select width (frame format fixes it at 2)
ADDR_LEN, 12, bus address width (frame format fixes it at 12)
DATA_LEN, 8, data/byte width
BURST_LEN, 12, burst count width (frame format fixes it at 12)
FIFO_DEPTH, 4, entries in each of the write-data and read-data FIFOs; power of 2, at least 2
TIMEOUT_CYCLES, 100000, idle clocks allowed between frame bytes before abort; at least 1

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high
u_receive_sig  in  1  one-cycle pulse: u_data_in is valid
u_data_in  in  DATA_LEN  received UART byte
u_tx_busy  in  1  UART transmitter busy
u_tx_done  in  1  one-cycle pulse: byte transmitted
u_send_sig  out  1  one-cycle pulse: start transmit of u_data_out
u_data_out  out  DATA_LEN  byte to transmit
m_instruction  out  2  00 idle, 01 read, 10 write; non-zero for exactly one cycle per transaction
m_slave_select  out  SLAVE_LEN  target slave
m_address  out  ADDR_LEN  start address
m_burst_num  out  BURST_LEN  byte count
m_data_out  out  DATA_LEN  write data (write FIFO head)
m_data_in  in  DATA_LEN  read data from bridge
m_new_rx  in  1  one-cycle pulse: m_data_in valid
m_rx_done  in  1  one-cycle pulse: read burst complete
m_tx_done  in  1  one-cycle pulse: current write byte accepted
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky; frame aborted on timeout
err_overflow  out  1  sticky; read byte dropped because the read FIFO was full

Behaviour:
- Reset: all outputs 0, FSM in IDLE, both FIFOs empty, counters 0, sticky flags cleared. Reset applied mid-transaction aborts at once; the bridge sees m_instruction=00.
- Frame bytes: B0 = [7:6] op, [5:4] slave, [3:0] addr[11:8]; B1 = addr[7:0]; B2 = [3:0] burst[11:8] ([7:4] ignored); B3 = burst[7:0]. A write frame is followed by burst data bytes.
- FSM states: IDLE, ADDR, BHI, BLO, ISSUE, WRITE, READ, DRAIN.
  - IDLE: on u_receive_sig, latch B0. If op is 00 or 11, discard the byte and stay in IDLE. Otherwise go to ADDR.
  - ADDR -> BHI -> BLO: each transition occurs on u_receive_sig and latches its byte.
  - BLO: if burst == 0, return to IDLE with no bus activity. Otherwise go to ISSUE.
  - ISSUE, read: drive m_instruction=01 for 1 cycle, then go to READ.
  - ISSUE, write: wait until the write FIFO is non-empty, drive m_instruction=10 for 1 cycle, then go to WRITE.
  - WRITE: m_data_out = write FIFO head. Each m_tx_done pops the FIFO and increments the count. When count reaches burst on an m_tx_done, go to DRAIN.
  - READ: each m_new_rx pushes m_data_in into the read FIFO. m_rx_done moves to DRAIN.
  - DRAIN: stay until the read FIFO is empty and no UART send is in flight, then go to IDLE.
- Address, slave and burst outputs stay stable from ISSUE until IDLE is re-entered.
- Write FIFO: UART bytes are pushed while in ISSUE or WRITE until burst bytes have been received. Bytes received beyond the burst, or while the FIFO is full, are dropped.
- UART TX: pulse u_send_sig when the read FIFO is non-empty, u_tx_busy=0 and no send is in flight. Pop the FIFO on the same cycle. The in-flight flag clears on u_tx_done.
- Simultaneous m_new_rx and pop on a full read FIFO: the pop is processed first, so no overflow occurs.
- m_new_rx on a full read FIFO without a pop: the byte is dropped and err_overflow is set.
- Timeout: the counter runs in ADDR, BHI and BLO, and in WRITE while the write FIFO is empty with bytes still owed. It clears on every u_receive_sig. At TIMEOUT_CYCLES: set err_timeout, flush the write FIFO, go to IDLE.
  - In WRITE, bridge back-pressure is not timed: the counter is held while the write FIFO is non-empty.
  - Timeout abort from WRITE mid-burst: the FSM returns to IDLE and m_instruction stays 00.
- The counter and FIFO pointers are sized with $clog2 and wrap modulo depth.

Optional Feature:
STATUS_ACK_EN:
- Defined: a state ACK is inserted between DRAIN and IDLE. It queues one status byte onto the UART TX path:
  - 8'hA5 when the transaction completed without error;
  - 8'hE0 | {err_overflow, err_timeout} otherwise.
- A timeout abort also passes through ACK.
- Undefined: no status byte is sent and DRAIN goes directly to IDLE.

Test Plan:
1. Write: UART bytes 0x94,0x10,0x00,0x02,0xAA,0x55 -> one m_instruction=10 pulse, slave=1, addr=0x410, burst=2; m_data_out=0xAA then 0x55 across two m_tx_done; busy then falls.
2. Read: 0x63,0x20,0x00,0x03, then bridge returns 0x11,0x22,0x33 and m_rx_done -> m_instruction=01 with addr=0x320; UART sends 0x11,0x22,0x33 in order, one per u_tx_done.
3. Overflow: read burst 6, u_tx_busy held high, 6 m_new_rx pulses -> first 4 bytes buffered, err_overflow=1, 4 bytes sent once busy drops.
4. Timeout: 0x94,0x10 then silence for TIMEOUT_CYCLES -> err_timeout=1, FSM IDLE, no m_instruction pulse.
5. Reset mid-write: reset asserted after the first m_tx_done -> next cycle all outputs 0, busy=0; a subsequent valid frame executes normally.
6. Illegal op/zero burst: B0=0xC0 is dropped; frame 0x94,0x10,0x00,0x00 -> no bus activity, returns to IDLE (with STATUS_ACK_EN: 0xA5 sent for the zero-burst frame).
